// File: rtl/uart_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and line levels for the UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer_if
// Description : First-word-fall-through FIFO read port seen by the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if #(
    parameter int bw = 8
);
    logic [bw-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;

    // master pops the FIFO, slave is the FIFO read side
    modport master (output fifo_rd_en, input fifo_dout, input fifo_empty);
    modport slave  (input fifo_rd_en, output fifo_dout, output fifo_empty);
endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period down-counter; tick marks the last cycle of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int div_w = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [div_w-1:0] div,
    output logic             tick
);
    logic [div_w-1:0] r_cnt;

    // Reloads on its own at every bit end so consecutive bits need no load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load || (r_cnt == '0)) begin
            r_cnt <= div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Drains a FWFT FIFO and serializes each word as a UART frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int bw    = 8,
    parameter int div_w = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic [div_w-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    uart_tx_serializer_if.master fif,
    output logic                 txd,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int              IDX_W       = (bw > 2) ? $clog2(bw) : 1;
    localparam logic [IDX_W-1:0] c_last_data = IDX_W'(bw - 1);

    uart_tx_state_t   r_state, w_state_nxt;
    logic [bw-1:0]    r_shift, w_shift_nxt;
    logic             r_par, w_par_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [div_w-1:0] r_div;
    logic             r_par_en, r_par_odd, r_stop2;
    logic             w_tick, w_pop, w_last_stop, w_txd_nxt, w_done_nxt;
    logic [div_w-1:0] w_div;

    assign w_last_stop   = (r_state == ST_STOP) && w_tick && (r_idx == IDX_W'(r_stop2));
    assign w_pop         = tx_en && !fif.fifo_empty && ((r_state == ST_IDLE) || w_last_stop);
    assign fif.fifo_rd_en = w_pop && rst_n;
    // The latched divisor is only written on the pop edge, so the counter takes the live value then.
    assign w_div         = w_pop ? baud_div : r_div;

    uart_baud_cnt #(.div_w(div_w)) u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_pop),
        .div   (w_div),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
            end
            ST_START: if (w_tick) begin
                w_state_nxt = ST_DATA;
                w_idx_nxt   = '0;
            end
            ST_DATA: if (w_tick) begin
                w_par_nxt   = r_par ^ r_shift[0];
                w_shift_nxt = r_shift >> 1;
                if (r_idx == c_last_data) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            ST_PARITY: if (w_tick) begin
                w_state_nxt = ST_STOP;
                w_idx_nxt   = '0;
            end
            ST_STOP: if (w_tick) begin
                if (w_last_stop) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_pop) begin
            w_state_nxt = ST_START;
            w_shift_nxt = fif.fifo_dout;
            w_par_nxt   = 1'b0;
            w_idx_nxt   = '0;
        end

        // txd is registered from the next state so the start bit follows the pop by one cycle.
        case (w_state_nxt)
            ST_START:  w_txd_nxt = UART_START_LVL;
            ST_DATA:   w_txd_nxt = w_shift_nxt[0];
            ST_PARITY: w_txd_nxt = w_par_nxt ^ r_par_odd;
            default:   w_txd_nxt = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_idx      <= '0;
            r_div      <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_stop2    <= 1'b0;
            txd        <= UART_IDLE_LVL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_idx      <= w_idx_nxt;
            txd        <= w_txd_nxt;
            busy       <= (w_state_nxt != ST_IDLE);
            frame_done <= w_done_nxt;
            if (w_pop) begin
                r_div     <= baud_div;
                r_par_en  <= parity_en;
                r_par_odd <= parity_odd;
                r_stop2   <= stop2;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench: frame-level line model plus directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;
    localparam int BW = 8;
    localparam int DW = 16;
    localparam int HN = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_en = 1'b0;
    logic [DW-1:0] baud_div = 16'd3;
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          stop2 = 1'b0;
    logic          txd, busy, frame_done;

    uart_tx_serializer_if #(.bw(BW)) fif ();

    uart_tx_serializer #(.bw(BW), .div_w(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .fif        (fif),
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cnt = 0;
    int pop_cyc[$];
    int fd_cyc[$];
    logic txd_hist [0:HN-1];
    logic [BW-1:0] fq[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO read side: pops on the strobe, head/empty refreshed shortly after each edge
    initial begin
        fif.fifo_dout  = '0;
        fif.fifo_empty = 1'b1;
        forever begin
            @(posedge clk);
            if (fif.fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
            #2;
            fif.fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
            fif.fifo_empty = (fq.size() == 0);
        end
    end

    // Line model: a popped word becomes its list of bit levels, each held baud_div+1 cycles
    logic m_txd = 1'b1, m_busy = 1'b0, m_fd = 1'b0, m_rd, m_last;
    logic m_line[$];

    task automatic build_frame(input logic [BW-1:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < BW; i++) bits.push_back(d[i]);
        if (parity_en) bits.push_back((^d) ^ parity_odd);
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        foreach (bits[i])
            for (int j = 0; j <= int'(baud_div); j++) m_line.push_back(bits[i]);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_line.delete();
            m_txd = 1'b1; m_busy = 1'b0; m_fd = 1'b0; m_rd = 1'b0; m_last = 1'b0;
        end else begin
            m_last = m_busy && (m_line.size() == 0);
            m_rd   = tx_en && (fq.size() > 0) && (!m_busy || m_last);
        end
        chk("txd", txd, m_txd);
        chk("busy", busy, m_busy);
        chk("frame_done", frame_done, m_fd);
        chk("fifo_rd_en", fif.fifo_rd_en, m_rd);
        txd_hist[cyc % HN] = txd;
        if (rst_n && fif.fifo_rd_en) pop_cyc.push_back(cyc);
        if (frame_done) fd_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        if (rst_n) begin
            m_fd = m_last;
            if (m_rd) build_frame(fq[0]);
            if (m_line.size() > 0) begin
                m_txd = m_line.pop_front(); m_busy = 1'b1;
            end else begin
                m_txd = 1'b1; m_busy = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BW-1:0] b);
        fq.push_back(b);
    endtask

    task automatic wait_fd(input int n, input int limit);
        int k = 0;
        while (fd_cyc.size() < n && k < limit) begin tick(1); k++; end
        chk("frame_done_wait", fd_cyc.size(), n);
    endtask

    task automatic wait_pop(input int n, input int limit);
        int k = 0;
        while (pop_cyc.size() < n && k < limit) begin tick(1); k++; end
        chk("pop_wait", pop_cyc.size(), n);
    endtask

    task automatic clear_log();
        pop_cyc.delete();
        fd_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] t1_bits;
        t1_bits = 10'h2AA;
        tick(3);
        chk("reset_txd", txd, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_frame_done", frame_done, 1'b0);
        chk("reset_rd_en", fif.fifo_rd_en, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // single 0x55, 8N1, 4-cycle bits
        clear_log();
        tx_en = 1'b1;
        push(8'h55);
        wait_fd(1, 100);
        tick(2);
        chk("t1_pops", pop_cyc.size(), 1);
        chk("t1_fd_latency", fd_cyc[0] - pop_cyc[0], 41);
        for (int i = 0; i < 10; i++)
            chk("t1_bit", txd_hist[(pop_cyc[0] + 2 + 4 * i) % HN], t1_bits[i]);

        // parity even / odd on 0xA3, then two stop bits
        for (int t = 0; t < 3; t++) begin
            clear_log();
            parity_en  = 1'b1;
            parity_odd = (t != 0);
            stop2      = (t == 2);
            push(8'hA3);
            wait_fd(1, 100);
            tick(2);
            chk("par_bit", txd_hist[(pop_cyc[0] + 38) % HN], (t != 0));
            chk("par_fd_latency", fd_cyc[0] - pop_cyc[0], (t == 2) ? 49 : 45);
        end
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;

        // tx_en low holds off a non-empty FIFO, then three frames back to back
        clear_log();
        tx_en = 1'b0;
        push(8'h01); push(8'h02); push(8'h03);
        tick(10);
        chk("hold_pops", pop_cyc.size(), 0);
        chk("hold_txd", txd, 1'b1);
        busy_cnt = 0;
        tx_en = 1'b1;
        wait_fd(3, 400);
        tick(3);
        chk("b2b_pops", pop_cyc.size(), 3);
        chk("b2b_gap01", pop_cyc[1] - pop_cyc[0], 40);
        chk("b2b_gap12", pop_cyc[2] - pop_cyc[1], 40);
        chk("b2b_busy_cycles", busy_cnt, 120);

        // tx_en dropped during data bits: frame completes, no further pop
        clear_log();
        push(8'h3C); push(8'h99);
        wait_pop(1, 20);
        tick(10);
        tx_en = 1'b0;
        wait_fd(1, 100);
        tick(50);
        chk("drop_pops", pop_cyc.size(), 1);
        chk("drop_fd", fd_cyc.size(), 1);
        fq.delete();
        tick(2);

        // reset during data bit 4 of 0xC3 (a 0 bit), then 0x5A starts cleanly
        clear_log();
        push(8'hC3); push(8'h5A);
        tx_en = 1'b1;
        wait_pop(1, 20);
        tick(21);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_txd", txd, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        tick(2);
        rst_n = 1'b1;
        wait_fd(1, 100);
        tick(2);
        chk("rst_pops", pop_cyc.size(), 2);
        chk("rst_next_latency", fd_cyc[0] - pop_cyc[1], 41);
        chk("rst_next_start", txd_hist[(pop_cyc[1] + 1) % HN], 1'b0);

        // divisor switched to 0 mid-frame: applies from the next frame
        clear_log();
        baud_div = 16'd3;
        push(8'h0F); push(8'hF0);
        wait_pop(1, 20);
        tick(5);
        baud_div = 16'd0;
        wait_fd(2, 200);
        tick(2);
        chk("div_fd0", fd_cyc[0] - pop_cyc[0], 41);
        chk("div_gap", pop_cyc[1] - pop_cyc[0], 40);
        chk("div_fd1", fd_cyc[1] - pop_cyc[1], 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit engine that drains the TX asynchronous FIFO from its read side and serializes each byte onto `txd`. It sits in the UART peripheral between the FIFO read port (`rd_clk` domain) and the pad. Per byte it generates a start bit, LSB-first data, optional parity and one or two stop bits, with a runtime-programmable bit period. It pops the FIFO using the first-word-fall-through convention: `dout` is valid whenever `empty` is low.

## Interface
- `bw`, default 8: data bits per frame; must equal the FIFO `bw`.
- `div_w`, default 16: width of the baud divisor.
- `clk`  in  1: single clock; the FIFO `rd_clk`.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `tx_en`  in  1: permits starting new frames.
- `baud_div`  in  div_w: clock cycles per bit minus 1.
- `parity_en`  in  1: appends a parity bit.
- `parity_odd`  in  1: selects odd parity (1) or even parity (0).
- `stop2`  in  1: selects two stop bits (1) or one (0).
- `fifo_dout`  in  bw: FIFO head word.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: one-cycle pop strobe.
- `txd`  out  1: serial line; idles high.
- `busy`  out  1: a frame is in progress.
- `frame_done`  out  1: one-cycle pulse after the last stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- `pop` = `tx_en` & !`fifo_empty` & (state==IDLE, or state==STOP & last stop bit ending).
- `fifo_rd_en` = `pop`. It is combinational and forced to 0 while `rst_n` is low.
- On `pop`, on the same edge:
  - shift register <= `fifo_dout`.
  - `baud_div`, `parity_en`, `parity_odd` and `stop2` are latched for the frame.
  - parity accumulator is cleared.
  - state -> START.
- Bit counter: a down-counter loaded with the latched divisor. A bit ends when the counter is 0, so each bit lasts `baud_div`+1 cycles.
- START: `txd`=0 for one bit, then -> DATA.
- DATA:
  - `txd` = shift[0]; shift right at each bit end.
  - After `bw` bits: -> PARITY if parity is enabled, else -> STOP.
- PARITY:
  - `txd` = XOR of the data bits, inverted when `parity_odd`.
  - Example: 0xA3 gives 0 for even parity, 1 for odd.
- STOP:
  - `txd`=1 for 1 or 2 bits.
  - At the end: `frame_done` pulses; state -> START if `pop`, else -> IDLE.
- `tx_en` deasserted mid-frame: the current frame completes; no new pop follows.
- Config inputs changed mid-frame: no effect until the next pop.
- `fifo_empty` is ignored outside the pop points.
- A divisor of 0 is legal: 1 cycle per bit.

## Timing
- Reset values: `txd`=1, `busy`=0, `frame_done`=0, `fifo_rd_en`=0, state=IDLE.
- Reset mid-frame: `txd` returns to 1 asynchronously. The byte in flight is lost and is not re-popped.
- `txd` is registered.
- Latency: the start bit appears on `txd` 1 cycle after the `fifo_rd_en` edge.
- Frame length: (1 + `bw` + `parity_en` + 1 + `stop2`) × (`baud_div`+1) cycles.
- Back-to-back frames: zero idle cycles. The next start bit begins on the cycle after the previous last stop bit.
- `busy`: high from the cycle after `pop` until the cycle after the final stop bit when no pop occurs.
- `frame_done`: asserted during the cycle following the last stop-bit cycle.
- FIFO `empty` updates on the pop edge, so `fifo_empty` is valid at every pop point.

## Structure
- Package `uart_pkg`: state enum `uart_tx_state_t`, plus localparams `UART_IDLE_LVL`=1'b1 and `UART_START_LVL`=1'b0.
- Sub-module `uart_baud_cnt`:
  - parameter `div_w`.
  - inputs: `clk`, `rst_n`, load, div.
  - output: `tick`, asserted at a bit end.
  - It is shared later with the RX sampler.
- Everything else is inline.

## Test plan
- Single byte: `bw`=8, `baud_div`=3, no parity, 1 stop, FIFO holds 0x55.
  - `fifo_rd_en` pulses once.
  - `txd` is 0, then 1,0,1,0,1,0,1,0, then 1, each bit for 4 cycles (40 cycles total).
  - `frame_done` pulses at cycle 41.
- Parity: byte 0xA3, `parity_en`=1.
  - `parity_odd`=0: parity bit is 0.
  - `parity_odd`=1: parity bit is 1.
  - `stop2`=1: frame is 48 cycles with `baud_div`=3.
- Back-to-back: FIFO holds 0x01, 0x02, 0x03.
  - Three pops, 40 cycles apart.
  - `txd` never idles between frames; `busy` stays high for 120 cycles.
- `tx_en`=0 with a non-empty FIFO: no pop, `txd`=1.
  - Drop `tx_en` during the DATA bits of a frame: that frame completes, no further pop.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 4.
  - `txd`=1 immediately; `busy`=0.
  - After release with the FIFO non-empty, the next byte starts cleanly.
- Divisor change: set `baud_div`=0 mid-frame (frame started at 3).
  - The current frame keeps 4-cycle bits.
  - The next frame uses 1-cycle bits (10 cycles).
